// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: E-stage request/response bundle between the pipeline and the HI/LO unit
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        rd_hi;
  logic        busy;
  logic [31:0] rdata;
  modport master(output start, op, a, b, req, rd_hi, input busy, rdata);
  modport slave(input start, op, a, b, req, rd_hi, output busy, rdata);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: MIPS-style HI/LO multiply/divide unit with a fixed-latency busy window
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave md
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t             r_state, w_next;
  logic [31:0]        r_hi, r_lo, r_hi_tmp, r_lo_tmp, r_cnt;
  logic               w_idle_go, w_launch, w_mul_op, w_div0;
  logic signed [63:0] w_smul;
  logic [63:0]        w_umul, w_prod;
  logic [31:0]        w_bs, w_hi_res, w_lo_res;
  logic signed [31:0] w_sq, w_sr;
  assign w_idle_go = md.start && !md.req && r_state == IDLE;
  assign w_launch  = w_idle_go && md.op >= 3'd1 && md.op <= 3'd4;
  assign w_mul_op  = md.op == 3'd1 || md.op == 3'd2;
  assign w_smul    = $signed(md.a) * $signed(md.b);
  assign w_umul    = {32'b0, md.a} * {32'b0, md.b};
  assign w_prod    = md.op == 3'd1 ? w_smul : w_umul;
  assign w_div0    = md.b == 32'd0;
  // Dividing by 1 instead of -1 makes the INT_MIN overflow case fall out as q=a, r=0
  assign w_bs      = (w_div0 || (md.op == 3'd3 && md.a == 32'h8000_0000 && md.b == 32'hffff_ffff)) ? 32'd1 : md.b;
  assign w_sq      = $signed(md.a) / $signed(w_bs);
  assign w_sr      = $signed(md.a) % $signed(w_bs);
  assign w_hi_res  = w_mul_op ? w_prod[63:32] : w_div0 ? r_hi : md.op == 3'd3 ? w_sr : md.a % w_bs;
  assign w_lo_res  = w_mul_op ? w_prod[31:0]  : w_div0 ? r_lo : md.op == 3'd3 ? w_sq : md.a / w_bs;
  assign md.busy   = r_state == BUSY;
  assign md.rdata  = md.rd_hi ? r_hi : r_lo;
  always_comb begin
    w_next = w_launch ? BUSY : (r_state == BUSY && r_cnt == 32'd1) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_hi_tmp <= '0;
      r_lo_tmp <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_cnt    <= w_mul_op ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
        r_hi_tmp <= w_hi_res;
        r_lo_tmp <= w_lo_res;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 32'd1;
        if (r_cnt == 32'd1) begin
          r_hi <= r_hi_tmp;
          r_lo <= r_lo_tmp;
        end
      end
      if (w_idle_go && md.op == 3'd5) r_hi <= md.a;
      if (w_idle_go && md.op == 3'd6) r_lo <= md.a;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for the HI/LO multiply/divide unit
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  int n;
  logic [31:0] hi, lo;
  mul_div_unit_if bus();
  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    bus.rd_hi = 1'b1;
    #1 h = bus.rdata;
    bus.rd_hi = 1'b0;
    #1 l = bus.rdata;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.req = rq;
    step();
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.req = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 50) begin
      cnt++;
      step();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    bus.req = 1'b0;
    bus.rd_hi = 1'b0;
    step();
    step();
    read_hilo(hi, lo);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    reset = 1'b1;
    step();

    issue(3'd1, 32'hffff_fffe, 32'd3, 1'b0);
    count_busy(n);
    read_hilo(hi, lo);
    chk("mult_busy", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hffff_ffff);
    chk("mult_lo", lo, 32'hffff_fffa);

    issue(3'd2, 32'hffff_ffff, 32'd2, 1'b0);
    count_busy(n);
    read_hilo(hi, lo);
    chk("multu_busy", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hffff_fffe);

    issue(3'd3, 32'hffff_fff9, 32'd2, 1'b0);
    count_busy(n);
    read_hilo(hi, lo);
    chk("div_busy", 32'(n), 32'd10);
    chk("div_hi", hi, 32'hffff_ffff);
    chk("div_lo", lo, 32'hffff_fffd);

    issue(3'd3, 32'h8000_0000, 32'hffff_ffff, 1'b0);
    count_busy(n);
    read_hilo(hi, lo);
    chk("div_ovf_hi", hi, 32'h0);
    chk("div_ovf_lo", lo, 32'h8000_0000);

    issue(3'd5, 32'h11, 32'h0, 1'b0);
    issue(3'd6, 32'h22, 32'h0, 1'b0);
    read_hilo(hi, lo);
    chk("mthi", hi, 32'h11);
    chk("mtlo", lo, 32'h22);
    issue(3'd4, 32'h1234, 32'h0, 1'b0);
    count_busy(n);
    read_hilo(hi, lo);
    chk("div0_busy", 32'(n), 32'd10);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    issue(3'd4, 32'hffff_fff0, 32'd7, 1'b0);
    count_busy(n);
    read_hilo(hi, lo);
    chk("divu_hi", hi, 32'h2);
    chk("divu_lo", lo, 32'h2492_4922);

    issue(3'd1, 32'd7, 32'd9, 1'b1);
    chk("req_mult_busy", 32'(bus.busy), 32'd0);
    issue(3'd5, 32'd5, 32'd0, 1'b1);
    step();
    read_hilo(hi, lo);
    chk("req_hi", hi, 32'h2);
    chk("req_lo", lo, 32'h2492_4922);

    issue(3'd3, 32'd100, 32'd7, 1'b0);
    n = 0;
    while (bus.busy && n < 50) begin
      n++;
      if (n == 3) bus.req = 1'b1;
      if (n == 5) begin
        bus.start = 1'b1;
        bus.op = 3'd6;
        bus.a = 32'hdead;
        bus.b = 32'd1;
      end
      step();
      bus.req = 1'b0;
      bus.start = 1'b0;
      bus.op = 3'd0;
    end
    read_hilo(hi, lo);
    chk("busy_req_count", 32'(n), 32'd10);
    chk("busy_req_hi", hi, 32'd2);
    chk("busy_req_lo", lo, 32'd14);

    issue(3'd3, 32'hffff_fff9, 32'd2, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    read_hilo(hi, lo);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    for (int i = 0; i < 12; i++) step();
    read_hilo(hi, lo);
    chk("rst_discard_hi", hi, 32'h0);
    chk("rst_discard_lo", lo, 32'h0);

    issue(3'd5, 32'h33, 32'h0, 1'b0);
    issue(3'd0, 32'h99, 32'h3, 1'b0);
    issue(3'd7, 32'h99, 32'h3, 1'b0);
    read_hilo(hi, lo);
    chk("nop_busy", 32'(bus.busy), 32'd0);
    chk("nop_hi", hi, 32'h33);
    chk("nop_lo", lo, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
